// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative RV32M multiply/divide unit
//
// Holds the funct3 op encodings, the FSM state type, the data/register widths
// and the iteration count shared by muldiv_unit and muldiv_addsub.
// Configuration macro: MULDIV_DIV_EN (consumed by muldiv_unit).

package muldiv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    // Within the divide group, funct3[1] selects remainder over quotient.
    function automatic logic op_is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// rtl/muldiv_addsub.sv - 33-bit add/subtract core shared by multiply and divide iterations
//
// Ports:
//   a, b  : 33-bit operands
//   sub   : 1 = a - b, 0 = a + b
//   sum   : 33-bit result
//   cout  : carry out; when subtracting, 1 means no borrow (a >= b)

module muldiv_addsub
    import muldiv_pkg::*;
(
    input  logic [XLEN:0] a,
    input  logic [XLEN:0] b,
    input  logic          sub,
    output logic [XLEN:0] sum,
    output logic          cout
);

    logic [XLEN+1:0] full;

    // Subtraction is a + ~b + 1 so that a single adder serves both directions.
    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(XLEN+1){1'b0}}, sub};
    assign sum  = full[XLEN:0];
    assign cout = full[XLEN+1];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit with fixed 33-cycle latency
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start_i, op_i      : request and RV32M funct3, accepted only while idle
//   rs1_data_i         : operand A (dividend / multiplicand)
//   rs2_data_i         : operand B (divisor / multiplier)
//   rd_addr_i          : destination register, captured at accept
//   kill_i             : abort the in-flight operation
//   busy_o             : high from accept until the done cycle ends
//   done_o             : one-cycle result-valid pulse
//   result_o, rd_addr_o: result and destination, zero outside done_o
//   wr_en_o            : register-file write enable
// Configuration macro: MULDIV_DIV_EN builds the divide/remainder datapath;
// without it divide ops still take the full latency but return 0 and never write.

module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              kill_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              wr_en_o
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q;     // product high half / partial remainder
    logic [XLEN-1:0]   lo_q;     // multiplier then product low half / dividend then quotient
    logic [XLEN-1:0]   b_q;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   res_q;
    logic [REG_AW-1:0] rd_q;
    logic              neg_q;    // negate the magnitude result at the end

    logic accept, iterate, finalize;

    assign accept   = (state_q == ST_IDLE) && start_i && !kill_i;
    assign iterate  = (state_q == ST_CALC) && !kill_i && (cnt_q != CNT_W'(ITER_CNT));
    // The extra CALC cycle after the last iteration applies sign correction,
    // giving every op the same latency.
    assign finalize = (state_q == ST_CALC) && !kill_i && (cnt_q == CNT_W'(ITER_CNT));

    // ---------------- operand conditioning at accept ----------------
    op_e             op_in;
    logic            a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;

    assign op_in = op_e'(op_i);

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed & rs1_data_i[XLEN-1];
    assign b_neg = b_signed & rs2_data_i[XLEN-1];
    assign a_mag = a_neg ? (-rs1_data_i) : rs1_data_i;
    assign b_mag = b_neg ? (-rs2_data_i) : rs2_data_i;

    // A zero divisor yields an all-ones magnitude quotient and the dividend
    // magnitude as remainder; leaving the quotient un-negated and giving the
    // remainder the dividend's sign produces the architectural results directly.
    always_comb begin
        if (op_is_rem(op_in))
            neg_in = a_neg;
        else if (op_is_div(op_in))
            neg_in = (a_neg ^ b_neg) && (rs2_data_i != '0);
        else
            neg_in = a_neg ^ b_neg;
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   as_a, as_b, as_sum;
    logic            as_sub, as_cout;
    logic [XLEN:0]   addend;
    logic [XLEN-1:0] hi_n, lo_n;

    always_comb begin
        as_a   = {1'b0, hi_q};
        as_b   = {1'b0, b_q};
        as_sub = 1'b0;
`ifdef MULDIV_DIV_EN
        if (op_is_div(op_q)) begin
            as_a   = {hi_q, lo_q[XLEN-1]};
            as_sub = 1'b1;
        end
`endif
    end

    muldiv_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    always_comb begin
        // Shift-add: conditionally add the multiplicand, then shift {carry,hi,lo} right.
        addend = lo_q[0] ? as_sum : {1'b0, hi_q};
        hi_n   = addend[XLEN:1];
        lo_n   = {addend[0], lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        // Restoring divide: keep the difference only when it did not borrow.
        if (op_is_div(op_q)) begin
            if (as_cout) begin
                hi_n = as_sum[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

`ifndef MULDIV_DIV_EN
    logic unused_cout;
    assign unused_cout = as_cout;
`endif

    // ---------------- result selection ----------------
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   final_res;
`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0]   quo_s, rem_s;
    assign quo_s = neg_q ? (-lo_q) : lo_q;
    assign rem_s = neg_q ? (-hi_q) : hi_q;
`endif

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? (-prod) : prod;

    always_comb begin
        final_res = '0;
        case (op_q)
            OP_MUL:                       final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              final_res = quo_s;
            OP_REM, OP_REMU:              final_res = rem_s;
`endif
            default:                      final_res = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: begin
                if (kill_i)
                    state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(ITER_CNT))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_MUL;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            res_q <= '0;
            rd_q  <= '0;
            neg_q <= 1'b0;
        end else if (accept) begin
            op_q  <= op_in;
            cnt_q <= '0;
            hi_q  <= '0;
            rd_q  <= rd_addr_i;
            neg_q <= neg_in;
            if (op_is_div(op_in)) begin
                lo_q <= a_mag;
                b_q  <= b_mag;
            end else begin
                lo_q <= b_mag;
                b_q  <= a_mag;
            end
        end else if (iterate) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (finalize) begin
            res_q <= final_res;
        end
    end

    // ---------------- outputs ----------------
    logic wr_allowed;
`ifdef MULDIV_DIV_EN
    assign wr_allowed = 1'b1;
`else
    assign wr_allowed = !op_is_div(op_q);
`endif

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE) && !kill_i;
    assign result_o  = done_o ? res_q : '0;
    assign rd_addr_o = done_o ? rd_q : '0;
    assign wr_en_o   = done_o && (rd_q != '0) && wr_allowed;

endmodule
